// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op codes, FSM state encoding and default sizes for the
//               iterative multiply/divide unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int c_DEF_WIDTH      = 32;
    localparam int c_DEF_MUL_CYCLES = 5;

    localparam logic [3:0] c_OP_NONE  = 4'b0000;
    localparam logic [3:0] c_OP_MULT  = 4'b0001;
    localparam logic [3:0] c_OP_MULTU = 4'b0010;
    localparam logic [3:0] c_OP_DIV   = 4'b0011;
    localparam logic [3:0] c_OP_DIVU  = 4'b0100;
    localparam logic [3:0] c_OP_MTHI  = 4'b0101;
    localparam logic [3:0] c_OP_MTLO  = 4'b0110;
    localparam logic [3:0] c_OP_MADD  = 4'b0111;
    localparam logic [3:0] c_OP_MADDU = 4'b1000;
    localparam logic [3:0] c_OP_MSUB  = 4'b1001;
    localparam logic [3:0] c_OP_MSUBU = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_div_iter.sv
// ============================================================================
// Module      : mdu_div_iter
// Description : Radix-2 restoring divider, one quotient bit per step, with a
//               combinational sign fix-up presented while o_done is high.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_sgn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic               w_fit;

    assign w_a_mag = (i_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_sgn && i_b[WIDTH-1]) ? -i_b : i_b;

    // Partial remainder needs one extra bit for the trial compare; the
    // restored value always fits back into WIDTH bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fit   = (w_shift >= {1'b0, r_dvs});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_dvd   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= c_CNT_W'(WIDTH);
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_dvd   <= i_a;
            r_neg_q <= i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= i_sgn & i_a[WIDTH-1];
            r_dbz   <= (i_b == '0);
        end else if (i_step && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            r_rem <= w_fit ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fit};
        end
    end

    // The cycle after the last shift is the fix-up cycle.
    assign o_done = (r_cnt == '0);
    assign o_quo  = r_dbz ? '1    : (r_neg_q ? -r_quo : r_quo);
    assign o_rem  = r_dbz ? r_dvd : (r_neg_r ? -r_rem : r_rem);

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module      : mdu_iter
// Description : Multi-cycle multiply/divide unit owning HI/LO. Define
//               MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate ops.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int MUL_CYCLES = c_DEF_MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(MUL_CYCLES + 1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_sgn;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_mthi;
    logic               w_is_mtlo;
    logic               w_sgn;
    logic               w_mul_wr;
    logic               w_div_wr;
    logic               w_div_step;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
`ifdef MDU_MADD_EN
    logic               w_acc_add;
    logic               w_acc_sub;
    logic               r_acc_add;
    logic               r_acc_sub;
`endif

    always_comb begin
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        w_is_mthi = 1'b0;
        w_is_mtlo = 1'b0;
        w_sgn     = 1'b0;
`ifdef MDU_MADD_EN
        w_acc_add = 1'b0;
        w_acc_sub = 1'b0;
`endif
        case (op)
            c_OP_MULT:  begin w_is_mul = 1'b1; w_sgn = 1'b1; end
            c_OP_MULTU: w_is_mul = 1'b1;
            c_OP_DIV:   begin w_is_div = 1'b1; w_sgn = 1'b1; end
            c_OP_DIVU:  w_is_div = 1'b1;
            c_OP_MTHI:  w_is_mthi = 1'b1;
            c_OP_MTLO:  w_is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            c_OP_MADD:  begin w_is_mul = 1'b1; w_sgn = 1'b1; w_acc_add = 1'b1; end
            c_OP_MADDU: begin w_is_mul = 1'b1; w_acc_add = 1'b1; end
            c_OP_MSUB:  begin w_is_mul = 1'b1; w_sgn = 1'b1; w_acc_sub = 1'b1; end
            c_OP_MSUBU: begin w_is_mul = 1'b1; w_acc_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // A cancel arriving with start drops the start, mthi/mtlo included.
    assign w_accept = start & ~cancel & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_wr    = 1'b0;
        w_div_wr    = 1'b0;
        w_div_step  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_W'(1)) begin
                    w_mul_wr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                w_div_step = 1'b1;
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_div_done) begin
                    w_div_wr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ext_a = r_sgn ? {{WIDTH{r_opa[WIDTH-1]}}, r_opa} : {{WIDTH{1'b0}}, r_opa};
    assign w_ext_b = r_sgn ? {{WIDTH{r_opb[WIDTH-1]}}, r_opb} : {{WIDTH{1'b0}}, r_opb};
    assign w_prod  = w_ext_a * w_ext_b;

`ifdef MDU_MADD_EN
    // Accumulation reads HI/LO at completion; nothing else can write them
    // while the multiply is in flight.
    always_comb begin
        w_mul_res = w_prod;
        if (r_acc_add) begin
            w_mul_res = {r_hi, r_lo} + w_prod;
        end else if (r_acc_sub) begin
            w_mul_res = {r_hi, r_lo} - w_prod;
        end
    end
`else
    assign w_mul_res = w_prod;
`endif

    mdu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_accept & w_is_div),
        .i_step (w_div_step),
        .i_sgn  (w_sgn),
        .i_a    (a),
        .i_b    (b),
        .o_done (w_div_done),
        .o_quo  (w_div_quo),
        .o_rem  (w_div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_opa  <= '0;
            r_opb  <= '0;
            r_sgn  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
`ifdef MDU_MADD_EN
            r_acc_add <= 1'b0;
            r_acc_sub <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_accept && w_is_mul) begin
                r_opa <= a;
                r_opb <= b;
                r_sgn <= w_sgn;
                r_cnt <= c_CNT_W'(MUL_CYCLES);
`ifdef MDU_MADD_EN
                r_acc_add <= w_acc_add;
                r_acc_sub <= w_acc_sub;
`endif
            end else if (r_state == S_MUL) begin
                r_cnt <= cancel ? '0 : (r_cnt - c_CNT_W'(1));
            end

            if (w_mul_wr) begin
                {r_hi, r_lo} <= w_mul_res;
            end else if (w_div_wr) begin
                r_hi <= w_div_rem;
                r_lo <= w_div_quo;
            end else if (w_accept && w_is_mthi) begin
                r_hi <= a;
            end else if (w_accept && w_is_mtlo) begin
                r_lo <= a;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module      : tb_mdu_iter
// Description : Scoreboard bench for mdu_iter against an arithmetic model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DL = W + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cancel;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    mdu_iter #(
        .WIDTH      (W),
        .MUL_CYCLES (MC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] lat;
        logic [63:0] hl;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] m_hl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on {hi,lo}.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] hl);
        longint      sp;
        logic [63:0] up;
        int          sx;
        int          sy;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = {32'd0, x} * {32'd0, y};
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            4'd4: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            4'd5: return {x, hl[31:0]};
            4'd6: return {hl[63:32], x};
`ifdef MDU_MADD_EN
            4'd7:  return hl + sp;
            4'd8:  return hl + up;
            4'd9:  return hl - sp;
            4'd10: return hl - up;
`endif
            default: return hl;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        case (o)
            4'd1, 4'd2: return MC;
            4'd3, 4'd4: return DL;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return MC;
`endif
            default: return 0;
        endcase
    endfunction

    // Monitor: each busy run that ends retires one scoreboard entry.
    int   busy_run  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (busy === 1'b1) begin
            busy_run++;
        end else begin
            if (prev_busy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_busy: got run of %0d cycles expected none", busy_run);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", 64'(busy_run), {32'd0, e.lat});
                    check("hilo", {hi, lo}, e.hl);
                end
            end
            busy_run = 0;
        end
        prev_busy = busy;
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got busy %b after %0d cycles expected 0", busy, k);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int   l;
        exp_t e;
        l = lat_of(o);
        e.lat = 32'(l);
        e.hl  = model(o, x, y, m_hl);
        if (l > 0) sb_q.push_back(e);
        issue(o, x, y);
        m_hl = e.hl;
        if (l > 0) begin
            wait_idle();
        end else begin
            check("busy_quiet", {63'd0, busy}, 64'd0);
            check("hilo_direct", {hi, lo}, e.hl);
        end
    endtask

    // Abort a long op n cycles after its first busy cycle, by cancel or reset.
    task automatic run_abort(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             input int n, input bit use_reset);
        exp_t e;
        e.lat = 32'(n + 1);
        e.hl  = use_reset ? 64'd0 : m_hl;
        sb_q.push_back(e);
        issue(o, x, y);
        repeat (n) @(posedge clk);
        #1;
        if (use_reset) reset = 1'b1;
        else cancel = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cancel = 1'b0;
        m_hl   = e.hl;
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0]  ops [12];
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        exp_t        e;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd13};

        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 4'd0;
        a      = '0;
        b      = '0;
        m_hl   = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);

        run_op(4'd1, 32'hFFFF_FFFD, 32'd5);
        check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(4'd2, 32'hFFFF_FFFD, 32'd5);
        check("plan_multu", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
        run_op(4'd4, 32'd100, 32'd7);
        check("plan_divu", {hi, lo}, {32'd2, 32'd14});
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("plan_div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd3, 32'h1234_5678, 32'd0);
        check("plan_div_zero", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("plan_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(4'd6, 32'hA5A5_A5A5, 32'd0);
        check("plan_mtlo", {32'd0, lo}, 64'h0000_0000_A5A5_A5A5);
        run_op(4'd5, 32'h5A5A_0000, 32'd0);

        // Starts while busy must be ignored, including mthi.
        e.lat = 32'(DL);
        e.hl  = model(4'd4, 32'd1000, 32'd9, m_hl);
        sb_q.push_back(e);
        issue(4'd4, 32'd1000, 32'd9);
        m_hl = e.hl;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        op = 4'd1; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        run_abort(4'd4, 32'd1000, 32'd3, 9, 1'b0);
        run_abort(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, MC - 1, 1'b0);
        run_abort(4'd3, 32'hF000_0001, 32'd7, DL - 1, 1'b0);

        // cancel with start in IDLE drops an mtlo
        start = 1'b1; op = 4'd6; a = 32'h0BAD_F00D; cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_lo", {hi, lo}, m_hl);
        check("cancel_start_busy", {63'd0, busy}, 64'd0);

        run_op(4'd5, 32'h1111_2222, 32'd0);
        run_abort(4'd3, 32'h7FFF_0000, 32'd13, 9, 1'b1);
        check("reset_midop", {hi, lo}, 64'd0);

        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd6, 32'd1, 32'd0);
        run_op(4'd7, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        check("plan_madd", {hi, lo}, 64'd13);
`else
        check("plan_madd_off", {hi, lo}, 64'd1);
`endif
        run_op(4'd10, 32'd1, 32'd14);
`ifdef MDU_MADD_EN
        check("plan_msubu", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        check("plan_msubu_off", {hi, lo}, 64'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 11)];
            x = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_op(o, x, y);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
